// File: rtl/sound_pkg.sv
// Event and FSM encodings plus the fixed per-event note tables for the sound arbiter.
package sound_pkg;

   typedef enum logic [1:0] {SND_COLLISION, SND_SCORED, SND_WIN, SND_LOSE} sound_e;
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

   localparam logic [1:0] COLLISION_NOTES = 2'd1;
   localparam logic [1:0] SCORED_NOTES    = 2'd2;
   localparam logic [1:0] WIN_NOTES       = 2'd3;
   localparam logic [1:0] LOSE_NOTES      = 2'd3;

   // Element [0] is the first note played.
   localparam logic [2:0][3:0] COLLISION_TABLE = {4'd0,  4'd0, 4'd1};
   localparam logic [2:0][3:0] SCORED_TABLE    = {4'd0,  4'd5, 4'd3};
   localparam logic [2:0][3:0] WIN_TABLE       = {4'd12, 4'd8, 4'd5};
   localparam logic [2:0][3:0] LOSE_TABLE      = {4'd1,  4'd4, 4'd7};

   function automatic logic [1:0] noteCount(input sound_e snd);
      case (snd)
         SND_COLLISION: return COLLISION_NOTES;
         SND_SCORED:    return SCORED_NOTES;
         SND_WIN:       return WIN_NOTES;
         default:       return LOSE_NOTES;
      endcase
   endfunction

   function automatic logic [3:0] noteLookup(input sound_e snd, input logic [1:0] ptr);
      logic [2:0][3:0] tbl;
      case (snd)
         SND_COLLISION: tbl = COLLISION_TABLE;
         SND_SCORED:    tbl = SCORED_TABLE;
         SND_WIN:       tbl = WIN_TABLE;
         default:       tbl = LOSE_TABLE;
      endcase
      return (ptr == 2'd3) ? 4'd0 : tbl[ptr];
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_CYCLES clocks, restarted by clear.
module ms_tick_gen #(
   parameter int TICK_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(TICK_CYCLES + 1);

   logic [CW-1:0] count;

   assign tick = (count == CW'(TICK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sound_event_arbiter.sv
// Latches game event pulses and plays the highest-priority event's note sequence on the tone generator.
// Outputs registered: pulse to tone is two cycles; higher-priority requests pre-empt, others wait in pending.
module sound_event_arbiter
   import sound_pkg::*;
#(
   parameter int TICK_CYCLES = 50000,
   parameter int NOTE_MS     = 100,
   parameter int GAP_MS      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       losePulse,
   input  logic       winPulse,
   input  logic       scoredPulse,
   input  logic       collisionPulse,
   input  logic       mute,
   output logic [3:0] tone_idx,
   output logic       tone_en,
   output logic       busy,
   output logic [1:0] sound_id
);

   localparam int MAX_MS = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
   localparam int MS_W   = $clog2(MAX_MS + 1);

   state_e          state, stateNext;
   sound_e          soundId, soundIdNext, grantIdx;
   logic [1:0]      notePtr, notePtrNext;
   logic [3:0]      pending, pulses, grantMask;
   logic [MS_W-1:0] msCount;
   logic            tick, timerClear, expire, preempt;

   assign pulses = {losePulse, winPulse, scoredPulse, collisionPulse};

   ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) tickGen (
      .clk   (clk),
      .reset (reset),
      .clear (timerClear),
      .tick  (tick)
   );

   assign expire = tick && ((state == S_PLAY) ? (msCount == MS_W'(NOTE_MS - 1))
                                              : (msCount == MS_W'(GAP_MS - 1)));

   always_comb begin
      grantIdx = SND_COLLISION;
      if (pending[3])      grantIdx = SND_LOSE;
      else if (pending[2]) grantIdx = SND_WIN;
      else if (pending[1]) grantIdx = SND_SCORED;
   end

   always_comb begin
      case (soundId)
         SND_COLLISION: preempt = |pending[3:1];
         SND_SCORED:    preempt = |pending[3:2];
         SND_WIN:       preempt = pending[3];
         default:       preempt = 1'b0;
      endcase
   end

   always_comb begin
      stateNext   = state;
      soundIdNext = soundId;
      notePtrNext = notePtr;
      grantMask   = 4'b0000;
      case (state)
         S_IDLE: begin
            if (|pending) begin
               stateNext   = S_PLAY;
               soundIdNext = grantIdx;
               notePtrNext = 2'd0;
               grantMask   = 4'b0001 << grantIdx;
            end
         end
         S_PLAY: begin
            if (preempt)     stateNext = S_IDLE;
            else if (expire) stateNext = S_GAP;
         end
         S_GAP: begin
            if (preempt) begin
               stateNext = S_IDLE;
            end else if (expire) begin
               if ((notePtr + 2'd1) == noteCount(soundId)) begin
                  stateNext = S_IDLE;
               end else begin
                  stateNext   = S_PLAY;
                  notePtrNext = notePtr + 2'd1;
               end
            end
         end
         default: stateNext = S_IDLE;
      endcase
      // Every state change starts a fresh note/gap interval.
      timerClear = (stateNext != state);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         soundId  <= SND_COLLISION;
         notePtr  <= 2'd0;
         pending  <= 4'b0000;
         msCount  <= '0;
         tone_idx <= 4'd0;
         tone_en  <= 1'b0;
         busy     <= 1'b0;
         sound_id <= 2'd0;
      end else begin
         state    <= stateNext;
         soundId  <= soundIdNext;
         notePtr  <= notePtrNext;
         // A pulse arriving on its own grant cycle survives the clear and replays once.
         pending  <= (pending & ~grantMask) | pulses;
         if (timerClear)  msCount <= '0;
         else if (tick)   msCount <= msCount + 1'b1;
         tone_idx <= (stateNext == S_PLAY) ? noteLookup(soundIdNext, notePtrNext) : 4'd0;
         tone_en  <= (stateNext == S_PLAY) && !mute;
         busy     <= (stateNext != S_IDLE);
         sound_id <= soundIdNext;
      end
   end

endmodule

// File: doc/sound_event_arbiter.md
# sound_event_arbiter

Shares the single tone generator between the game event sources (lose, win, scored, collision pulses from the game controller and the hit unit). It latches every single-cycle event pulse, grants the highest-priority pending event, and plays that event's fixed note sequence by driving a note index and an enable to the tone generator. Higher-priority events pre-empt lower ones. It sits between the game control logic and the audio datapath.

## Interface
Parameters:
- TICK_CYCLES, 50000, clk cycles per millisecond tick (50 MHz clock). Set small in simulation.
- NOTE_MS, 100, length of each note in ms ticks. Must be ≥ 1.
- GAP_MS, 20, length of the silence after each note in ms ticks. Must be ≥ 1.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- losePulse, in, 1: lose event, a single-cycle pulse. Priority 3 (highest).
- winPulse, in, 1: win event. Priority 2.
- scoredPulse, in, 1: ball-in-hole event. Priority 1.
- collisionPulse, in, 1: ball collision event. Priority 0.
- mute, in, 1: forces tone_en to 0. Sequencing and timing continue unchanged.
- tone_idx, out, 4: note index sent to the tone generator.
- tone_en, out, 1: tone generator enable.
- busy, out, 1: high whenever the state is not S_IDLE.
- sound_id, out, 2: event currently granted (0 = collision … 3 = lose). Only meaningful while busy.

## Operation
- Pending register, 4 bits, one per event.
  - A bit is set by its pulse.
  - The bit is cleared on the cycle its event is granted.
  - A pulse on the same cycle as that event's grant leaves the bit set, so the event replays once.
  - There is no counting beyond one pending request per event.
- Note tables, indexed by event:
  - collision: 1 note, {1}.
  - scored: 2 notes, {3, 5}.
  - win: 3 notes, {5, 8, 12}.
  - lose: 3 notes, {7, 4, 1}.
- FSM states:
  - S_IDLE: if any pending bit is set, grant the highest one, set note_ptr = 0 and go to S_PLAY. Otherwise stay.
  - S_PLAY: tone_en = ~mute, tone_idx = table[sound_id][note_ptr]. When the note timer expires, go to S_GAP.
  - S_GAP: tone_en = 0. When the timer expires:
    - if more notes remain, increment note_ptr and go to S_PLAY;
    - otherwise go to S_IDLE.
- Pre-emption:
  - Applies in S_PLAY or S_GAP, when any pending bit of strictly higher priority than sound_id is set.
  - The FSM goes to S_IDLE on the next edge, and the current event is dropped (not re-queued).
  - S_IDLE then grants normally.
  - Equal-priority or lower-priority requests wait.
- Timer:
  - On every entry to S_PLAY or S_GAP, clear the tick prescaler and the ms counter.
  - The timer expires on the tick for which ms_count == LEN-1, where LEN is NOTE_MS or GAP_MS.
- Outputs are registered.

## Timing
- Reset values: tone_idx = 0, tone_en = 0, busy = 0, sound_id = 0, pending = 0, state = S_IDLE, timers = 0.
- Pulse-to-sound latency:
  - pulse high in cycle c;
  - pending visible in c+1;
  - busy, tone_en and tone_idx visible in c+2.
- Note length: tone_en is high for exactly NOTE_MS·TICK_CYCLES cycles.
- Gap length: tone_en is low for exactly GAP_MS·TICK_CYCLES cycles.
- After the final gap, busy drops for at least 1 cycle (S_IDLE) before the next grant.
- Sequence durations:
  - collision: (NOTE_MS+GAP_MS)·TICK_CYCLES.
  - scored: twice that.
  - win and lose: three times that.
- Simultaneous pulses: all are latched and played in strict priority order, back to back.
- Pre-emption: tone_en falls on the edge after the higher pending bit is visible. The new grant follows one cycle later.
- Reset mid-sequence: all state and outputs return to their reset values on the next edge, and pending pulses are lost.
- mute toggled mid-note: only tone_en is affected, on the next edge. Timing is unchanged.

## Structure
- Package sound_pkg:
  - typedef enum sound_e {SND_COLLISION, SND_SCORED, SND_WIN, SND_LOSE};
  - FSM state enum;
  - note-count and note-table constants.
- Sub-module ms_tick_gen: prescaler with synchronous clear and a one-cycle tick output every TICK_CYCLES.

## Test plan
Parameters for all scenarios: TICK_CYCLES = 4, NOTE_MS = 3, GAP_MS = 2.
- Single collisionPulse at cycle 10:
  - tone_en high in cycles 12–23 (12 cycles) with tone_idx = 1;
  - busy low at cycle 32.
- losePulse, winPulse and scoredPulse on the same cycle:
  - tone_idx plays 7, 4, 1, then 5, 8, 12, then 3, 5;
  - each note lasts 12 cycles, each gap 8 cycles;
  - busy drops for 1 cycle between events.
- Pre-emption: scoredPulse, then losePulse 5 cycles into the first note:
  - tone_en falls 2 cycles after the lose pulse;
  - the lose sequence starts 1 cycle later;
  - the scored event never resumes.
- No pre-emption at equal or lower priority: collisionPulse during a win sequence:
  - the win sequence completes untouched;
  - collision plays afterwards.
- mute high during the second win note: tone_en stays 0 while tone_idx = 8 and the timing are unchanged.
- reset asserted mid-note with a lower event still pending: all outputs are 0 next cycle, and nothing plays afterwards.
